// File: rtl/bp_me_pkg.sv
// ============================================================================
// bp_me_pkg: CCE-to-memory message types, config constants, serializer helpers.
// Revision: 1.0
// ============================================================================
`default_nettype none

package bp_me_pkg;

    localparam int c_paddr_width     = 40;
    localparam int c_cce_block_width = 512;
    localparam int c_lce_id_width    = 4;
    localparam int c_lce_assoc       = 8;
    localparam int c_way_id_width    = $clog2(c_lce_assoc);

    typedef enum logic [3:0] {
        e_cce_mem_rd    = 4'b0000,
        e_cce_mem_wr    = 4'b0001,
        e_cce_mem_uc_rd = 4'b0010,
        e_cce_mem_uc_wr = 4'b0011,
        e_cce_mem_pre   = 4'b0100,
        e_cce_mem_amo   = 4'b0101
    } bp_cce_mem_cmd_type_e;

    typedef enum logic [2:0] {
        e_mem_size_1  = 3'd0,
        e_mem_size_2  = 3'd1,
        e_mem_size_4  = 3'd2,
        e_mem_size_8  = 3'd3,
        e_mem_size_16 = 3'd4,
        e_mem_size_32 = 3'd5,
        e_mem_size_64 = 3'd6
    } bp_mem_size_e;

    typedef struct packed {
        logic                      amo_no_return;
        logic                      speculative;
        logic                      uncached;
        logic                      prefetch;
        logic [2:0]                state;
        logic [c_way_id_width-1:0] way_id;
        logic [c_lce_id_width-1:0] did;
        logic [c_lce_id_width-1:0] lce_id;
    } bp_cce_mem_payload_s;

    typedef struct packed {
        bp_cce_mem_payload_s       payload;
        bp_mem_size_e              size;
        logic [c_paddr_width-1:0]  addr;
        bp_cce_mem_cmd_type_e      msg_type;
    } bp_cce_mem_msg_header_s;

    // Data sits above the header, so the header occupies the low bits of the message.
    typedef struct packed {
        logic [c_cce_block_width-1:0] data;
        bp_cce_mem_msg_header_s       header;
    } bp_cce_mem_msg_s;

    localparam int c_cce_mem_msg_width = $bits(bp_cce_mem_msg_s);
    localparam int c_hdr_width         = $bits(bp_cce_mem_msg_header_s);

    typedef enum logic [1:0] {
        e_ready  = 2'd0,
        e_header = 2'd1,
        e_data   = 2'd2
    } bp_me_ser_state_e;

    function automatic int unsigned bp_me_data_beats(
        input bp_cce_mem_cmd_type_e msg_type,
        input bp_mem_size_e         size,
        input int unsigned          link_width
    );
        int unsigned bits;
        bits = 32'd8 << size;
        if ((msg_type != e_cce_mem_wr) && (msg_type != e_cce_mem_uc_wr)) begin
            return 0;
        end
        return (bits <= link_width) ? 1 : bits / link_width;
    endfunction

endpackage

`default_nettype wire

// File: rtl/bp_me_beat_mux.sv
// ============================================================================
// bp_me_beat_mux: selects the BEAT_WIDTH slice at a beat index from a wide vector.
// Revision: 1.0
// ============================================================================
`default_nettype none

module bp_me_beat_mux #(
    parameter int VEC_WIDTH  = 512,
    parameter int BEAT_WIDTH = 64,
    parameter int IDX_WIDTH  = 4
) (
    input  logic [VEC_WIDTH-1:0]  vec_i,
    input  logic [IDX_WIDTH-1:0]  idx_i,
    output logic [BEAT_WIDTH-1:0] beat_o
);

    localparam int c_num_beats = VEC_WIDTH / BEAT_WIDTH;

    logic [c_num_beats-1:0][BEAT_WIDTH-1:0] w_beats;

    assign w_beats = vec_i;

    // Out-of-range indices yield zero rather than wrapping.
    always_comb begin
        beat_o = '0;
        for (int i = 0; i < c_num_beats; i++) begin
            if (idx_i == IDX_WIDTH'(i)) begin
                beat_o = w_beats[i];
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/bp_me_cce_mem_cmd_serializer.sv
// ============================================================================
// bp_me_cce_mem_cmd_serializer: streams one CCE mem command as header + data beats.
// Revision: 1.0
// ============================================================================
`default_nettype none

module bp_me_cce_mem_cmd_serializer
    import bp_me_pkg::*;
#(
    parameter int LINK_DATA_WIDTH = 64
) (
    input  logic                           clk_i,
    input  logic                           reset_n_i,
    input  logic [c_cce_mem_msg_width-1:0] mem_cmd_i,
    input  logic                           mem_cmd_v_i,
    output logic                           mem_cmd_ready_o,
    output logic [LINK_DATA_WIDTH-1:0]     link_data_o,
    output logic                           link_v_o,
    output logic                           link_last_o,
    input  logic                           link_ready_i
);

    localparam int c_hdr_beats   = (c_hdr_width + LINK_DATA_WIDTH - 1) / LINK_DATA_WIDTH;
    localparam int c_blk_beats   = c_cce_block_width / LINK_DATA_WIDTH;
    localparam int c_max_beats   = (c_hdr_beats > c_blk_beats) ? c_hdr_beats : c_blk_beats;
    localparam int c_cnt_width   = $clog2(c_max_beats + 1);
    localparam int c_hdr_ext_w   = c_hdr_beats * LINK_DATA_WIDTH;

    bp_me_ser_state_e             state_q;
    bp_cce_mem_msg_s              msg_q;
    logic [c_cnt_width-1:0]       cnt_q;
    logic                         ready_q;
    logic                         link_v_q;
    logic                         link_last_q;
    logic [LINK_DATA_WIDTH-1:0]   link_data_q;

    bp_cce_mem_msg_s              w_src;
    logic                         w_accept;
    logic                         w_handshake;
    logic [c_cnt_width-1:0]       w_src_beats;
    logic [c_cnt_width-1:0]       w_hdr_idx;
    logic [c_cnt_width-1:0]       w_data_idx;
    logic                         w_hdr_done;
    logic                         w_data_done;
    logic                         w_hdr_next_last;
    logic                         w_data_next_last;
    logic [c_hdr_ext_w-1:0]       w_hdr_ext;
    logic [LINK_DATA_WIDTH-1:0]   w_hdr_beat;
    logic [LINK_DATA_WIDTH-1:0]   w_data_beat;
    logic [LINK_DATA_WIDTH-1:0]   w_data_mask;
    int unsigned                  w_beat_bits;

    assign w_accept    = mem_cmd_v_i & ready_q;
    assign w_handshake = link_v_q & link_ready_i;

    // In e_ready the first header beat is prepared straight from the input so it
    // is registered onto the link at the accept edge.
    assign w_src       = (state_q == e_ready) ? bp_cce_mem_msg_s'(mem_cmd_i) : msg_q;
    assign w_src_beats = c_cnt_width'(bp_me_data_beats(w_src.header.msg_type,
                                                       w_src.header.size,
                                                       LINK_DATA_WIDTH));

    assign w_hdr_idx   = (state_q == e_ready) ? '0 : cnt_q + 1'b1;
    assign w_data_idx  = (state_q == e_data)  ? cnt_q + 1'b1 : '0;
    assign w_hdr_done  = (cnt_q == c_cnt_width'(c_hdr_beats - 1));
    assign w_data_done = (cnt_q == w_src_beats - 1'b1);

    assign w_hdr_next_last  = (w_hdr_idx == c_cnt_width'(c_hdr_beats - 1)) && (w_src_beats == '0);
    assign w_data_next_last = (w_data_idx == w_src_beats - 1'b1);

    always_comb begin
        w_hdr_ext                  = '0;
        w_hdr_ext[c_hdr_width-1:0] = w_src.header;
    end

    always_comb begin
        w_beat_bits = 32'd8 << w_src.header.size;
        for (int unsigned i = 0; i < LINK_DATA_WIDTH; i++) begin
            w_data_mask[i] = (i < w_beat_bits);
        end
    end

    bp_me_beat_mux #(
        .VEC_WIDTH  (c_hdr_ext_w),
        .BEAT_WIDTH (LINK_DATA_WIDTH),
        .IDX_WIDTH  (c_cnt_width)
    ) u_hdr_mux (
        .vec_i  (w_hdr_ext),
        .idx_i  (w_hdr_idx),
        .beat_o (w_hdr_beat)
    );

    bp_me_beat_mux #(
        .VEC_WIDTH  (c_cce_block_width),
        .BEAT_WIDTH (LINK_DATA_WIDTH),
        .IDX_WIDTH  (c_cnt_width)
    ) u_data_mux (
        .vec_i  (w_src.data),
        .idx_i  (w_data_idx),
        .beat_o (w_data_beat)
    );

    always_ff @(posedge clk_i) begin
        if (w_accept) begin
            msg_q <= bp_cce_mem_msg_s'(mem_cmd_i);
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q     <= e_ready;
            cnt_q       <= '0;
            ready_q     <= 1'b0;
            link_v_q    <= 1'b0;
            link_last_q <= 1'b0;
            link_data_q <= '0;
        end else begin
            case (state_q)
                e_ready: begin
                    ready_q <= 1'b1;
                    if (w_accept) begin
                        state_q     <= e_header;
                        cnt_q       <= '0;
                        ready_q     <= 1'b0;
                        link_v_q    <= 1'b1;
                        link_data_q <= w_hdr_beat;
                        link_last_q <= w_hdr_next_last;
                    end
                end
                e_header: begin
                    if (w_handshake) begin
                        if (!w_hdr_done) begin
                            cnt_q       <= cnt_q + 1'b1;
                            link_data_q <= w_hdr_beat;
                            link_last_q <= w_hdr_next_last;
                        end else if (w_src_beats != '0) begin
                            state_q     <= e_data;
                            cnt_q       <= '0;
                            link_data_q <= w_data_beat & w_data_mask;
                            link_last_q <= w_data_next_last;
                        end else begin
                            state_q     <= e_ready;
                            cnt_q       <= '0;
                            ready_q     <= 1'b1;
                            link_v_q    <= 1'b0;
                            link_last_q <= 1'b0;
                            link_data_q <= '0;
                        end
                    end
                end
                e_data: begin
                    if (w_handshake) begin
                        if (!w_data_done) begin
                            cnt_q       <= cnt_q + 1'b1;
                            link_data_q <= w_data_beat;
                            link_last_q <= w_data_next_last;
                        end else begin
                            state_q     <= e_ready;
                            cnt_q       <= '0;
                            ready_q     <= 1'b1;
                            link_v_q    <= 1'b0;
                            link_last_q <= 1'b0;
                            link_data_q <= '0;
                        end
                    end
                end
                default: begin
                    state_q <= e_ready;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    assign mem_cmd_ready_o = ready_q;
    assign link_v_o        = link_v_q;
    assign link_last_o     = link_last_q;
    assign link_data_o     = link_data_q;

endmodule

`default_nettype wire
